vga_line_prefetch: RTL and testbench
====================================

# vga_line_prefetch

Framebuffer line prefetcher that sits between the data-memory VGA read port and the VGA controller's colour inputs. It double-buffers one image line: while line r is displayed from the front buffer, line r+1 is read from data memory into the back buffer. It presents a registered 24-bit pixel to the controller for each (row, column) scan position. Positions outside the image window are driven black.

## Interface
Parameters:
- IMG_W, 200, image width in pixels (words per line)
- IMG_H, 200, image height in lines
- V_TOTAL, 525, total scan lines per frame, including blanking
- BASE_ADDR, 0, word address of pixel (0,0)
- AW, 16, memory address width

Ports:
- clk  in  1  pixel clock; same clock as the VGA controller
- reset  in  1  synchronous, active-low; sampled on rising clk
- row  in  10  current scan row from the VGA controller
- column  in  10  current scan column from the VGA controller
- mem_addr  out  AW  word address to the data-memory read port
- mem_rd_en  out  1  read strobe
- mem_rdata  in  32  read data; valid exactly 1 cycle after the address/strobe
- red, green, blue  out  8 each  pixel colour: mem word bits [7:0], [15:8], [23:16]
- busy  out  1  high while the fetch FSM is not IDLE
- overrun  out  1  sticky; set when a fetch trigger arrives while busy

## Operation
- Two line buffers, each IMG_W x 24 bits; `front_sel` selects the display buffer.
- Next row: nr = (row == V_TOTAL-1) ? 0 : row+1.
- Swap: every cycle with column == 0, `front_sel` toggles. The toggled value already applies to the pixel read in that same cycle.
- Trigger: column == 0 and nr < IMG_H. The fetch fills the buffer that becomes the back buffer after the swap.
  - Row 0 is fetched during row V_TOTAL-1.
  - Row r+1 is fetched during row r.
- Fetch FSM:
  - IDLE: on trigger, latch nr, set x = 0, go to FETCH.
  - FETCH: drive mem_addr = BASE_ADDR + nr*IMG_W + x, taken mod 2^AW, with mem_rd_en = 1. The mem_rdata returned for address x-1 is written to back[x-1]. Increment x. After issuing x = IMG_W-1, go to DRAIN.
  - DRAIN: mem_rd_en = 0; write the final word to back[IMG_W-1]; go to IDLE.
- Trigger while busy: the trigger is ignored, the fetch in progress continues, and overrun is set to 1. Overrun is cleared only by reset.
- Pixel output: if row < IMG_H and column < IMG_W, output front[column]; otherwise output 24'h000000.
- mem_addr holds its last value when idle. mem_rd_en is 0 in IDLE and DRAIN.
- Reset (reset == 0 on a clk edge) sets:
  - FSM to IDLE, x = 0
  - mem_addr = 0, mem_rd_en = 0
  - red = green = blue = 0
  - busy = 0, overrun = 0, front_sel = 0
- Reset in mid-fetch abandons the fetch. Buffer contents are not cleared and are undefined until refilled.

## Timing
- Pixel latency: red/green/blue in cycle t+1 reflect (row, column) sampled in cycle t.
- Fetch latency: the trigger in cycle t is observed by the FSM; the first mem_rd_en appears at t+1.
- mem_rd_en stays high for exactly IMG_W consecutive cycles.
- The last buffer write occurs in DRAIN, at t+IMG_W+1. busy is high from t+1 through t+IMG_W+1 (IMG_W+1 cycles) and returns low at t+IMG_W+2.
- With 800-cycle lines, a fetch (201 cycles) always completes before the next swap. Overrun indicates broken scan timing, not normal operation.
- Buffer write and display read target different buffers in every cycle, so there is no read/write collision.
- Address arithmetic is done at AW bits. The largest address at defaults is 39999, which does not wrap.

## Test plan
- Reset: hold reset = 0 for 3 cycles with row = 100, column = 50. Required: all outputs 0, busy = 0, overrun = 0. After release, no mem_rd_en until the next valid trigger.
- Frame start: drive row = 524, column = 0. Required:
  - mem_rd_en high for 200 cycles
  - mem_addr = 0, 1, …, 199 on consecutive cycles
  - busy high for 201 cycles
- Line fetch: at row = 0, column = 0, the fetch runs with mem_addr 200..399. At row = 199, column = 0, no trigger occurs (nr = 200): mem_rd_en stays 0 and busy stays 0.
- Pixel data: memory returns 0x00332211 for address 5 of line 0. Required at row = 0, column = 5: red = 0x11, green = 0x22, blue = 0x33 one cycle later. At row = 0, column = 250 and at row = 300, column = 5: all channels 0x00.
- Overrun: present column = 0 with row = 10, then row = 11, column = 0 again 50 cycles later. Required:
  - overrun = 1 and stays 1
  - the first fetch completes with addresses 2200..2399
  - the second trigger is ignored
- Mid-fetch reset: assert reset = 0 at the 100th address of a fetch. Required: mem_rd_en = 0 and busy = 0 on the next cycle, FSM in IDLE, overrun = 0. The next trigger restarts cleanly at x = 0.

Source files
------------

// File: rtl/vga_line_prefetch.sv
// Double-buffered framebuffer line prefetcher: shows line r from the front buffer
// while line r+1 streams from data memory into the back buffer.
module vga_line_prefetch #(
  parameter int IMG_W     = 200,
  parameter int IMG_H     = 200,
  parameter int V_TOTAL   = 525,
  parameter int BASE_ADDR = 0,
  parameter int AW        = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [9:0]    row,
  input  logic [9:0]    column,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd_en,
  input  logic [31:0]   mem_rdata,
  output logic [7:0]    red,
  output logic [7:0]    green,
  output logic [7:0]    blue,
  output logic          busy,
  output logic          overrun
);

  localparam int IW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [9:0]    W10   = 10'(IMG_W);
  localparam logic [10:0]   H11   = 11'(IMG_H);
  localparam logic [9:0]    VLAST = 10'(V_TOTAL - 1);
  localparam logic [IW-1:0] XLAST = IW'(IMG_W - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t        state_q;
  logic [IW-1:0] x_q;
  logic [AW-1:0] mem_addr_q;
  logic          rd_en_q;
  logic          busy_q;
  logic          overrun_q;
  logic          front_sel_q;
  logic          fill_sel_q;
  logic          wr_valid_q;
  logic [IW-1:0] wr_idx_q;
  logic          rd_sel_q;
  logic          pix_valid_q;

  logic [10:0]   next_row;
  logic          trigger;
  logic          pix_in;
  logic          rd_sel;
  logic [IW-1:0] rd_idx;
  logic [AW-1:0] start_addr;
  logic [23:0]   pix;
  logic          unused_rdata;

  assign next_row   = (row == VLAST) ? 11'd0 : ({1'b0, row} + 11'd1);
  assign trigger    = (column == 10'd0) && (next_row < H11);
  assign pix_in     = ({1'b0, row} < H11) && (column < W10);
  // The swap at column 0 already applies to the pixel read in that cycle.
  assign rd_sel     = (column == 10'd0) ? ~front_sel_q : front_sel_q;
  assign rd_idx     = pix_in ? column[IW-1:0] : '0;
  assign start_addr = AW'(BASE_ADDR) + AW'(32'(next_row) * 32'(IMG_W));
  assign unused_rdata = ^mem_rdata[31:24];

  // Fetch FSM plus scan-side registers; data for address x arrives one cycle later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      mem_addr_q  <= '0;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      front_sel_q <= 1'b0;
      fill_sel_q  <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_idx_q    <= '0;
      rd_sel_q    <= 1'b0;
      pix_valid_q <= 1'b0;
    end else begin
      wr_valid_q  <= rd_en_q;
      wr_idx_q    <= x_q;
      rd_sel_q    <= rd_sel;
      pix_valid_q <= pix_in;
      if (column == 10'd0) begin
        front_sel_q <= ~front_sel_q;
      end
      if (trigger && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (trigger) begin
            state_q    <= FETCH;
            x_q        <= '0;
            mem_addr_q <= start_addr;
            rd_en_q    <= 1'b1;
            busy_q     <= 1'b1;
            fill_sel_q <= front_sel_q;
          end
        end
        FETCH: begin
          if (x_q == XLAST) begin
            state_q <= DRAIN;
            rd_en_q <= 1'b0;
          end else begin
            x_q        <= x_q + 1'b1;
            mem_addr_q <= mem_addr_q + 1'b1;
          end
        end
        DRAIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          x_q     <= '0;
        end
        default: begin
          state_q <= IDLE;
          rd_en_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_buf
      logic [23:0] line_mem [IMG_W];
      logic [23:0] rd_q;
      always_ff @(posedge clk) begin
        if (wr_valid_q && (fill_sel_q == 1'(gi))) begin
          line_mem[wr_idx_q] <= mem_rdata[23:0];
        end
        rd_q <= line_mem[rd_idx];
      end
    end
  endgenerate

  assign pix       = pix_valid_q ? (rd_sel_q ? g_buf[1].rd_q : g_buf[0].rd_q) : 24'h000000;
  assign red       = pix[7:0];
  assign green     = pix[15:8];
  assign blue      = pix[23:16];
  assign mem_addr  = mem_addr_q;
  assign mem_rd_en = rd_en_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_vga_line_prefetch.sv
// Self-checking bench for vga_line_prefetch: line-level reference model, pixel table,
// hand-written fetch/overrun/reset sequences and randomized scan lines.
module tb_vga_line_prefetch;

  localparam int W = 200, H = 200, VT = 525, BASE = 0, AW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [9:0]    row = '0;
  logic [9:0]    column = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic [31:0]   mem_rdata = '0;
  logic [7:0]    red, green, blue;
  logic          busy, overrun;

  vga_line_prefetch #(.IMG_W(W), .IMG_H(H), .V_TOTAL(VT), .BASE_ADDR(BASE), .AW(AW)) dut (
    .clk(clk), .reset(reset), .row(row), .column(column),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .red(red), .green(green), .blue(blue), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  logic [31:0] mem_img [65536];

  // Data memory: read data valid one cycle after address/strobe.
  always @(posedge clk) mem_rdata <= (mem_rd_en === 1'b1) ? mem_img[mem_addr] : 32'h0;

  int errors = 0;
  int checks = 0;

  // Line-level reference model: each buffer slot holds a whole image line (or unknown).
  int          m_f = 0;       // cycles into the current fetch, 0 = idle
  int          m_line = 0;
  logic [15:0] m_start = '0;
  logic [15:0] m_addr = '0;
  bit          m_over = 0;
  bit          m_front = 0;
  bit          m_fill = 0;
  int          slot_line [2];
  bit          slot_ok [2];
  bit          exp_rd, exp_busy, exp_pix_known;
  logic [23:0] exp_pix;

  int          seq_rd, seq_busy, seq_bad;
  logic [15:0] seq_first, seq_prev;

  typedef struct {
    string       name;
    int          r;
    int          c;
    logic [23:0] rgb;
  } pix_vec_t;
  pix_vec_t vecs [8];

  function automatic logic [23:0] img(int l, int c);
    logic [31:0] w;
    w = mem_img[(BASE + l * W + c) % 65536];
    return w[23:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rst_n, input int r, input int c);
    int nr;
    bit trig, old_front, sel;
    if (!rst_n) begin
      m_f = 0; m_over = 0; m_front = 0; m_addr = '0;
      slot_ok[0] = 0; slot_ok[1] = 0;
      exp_rd = 0; exp_busy = 0; exp_pix = '0; exp_pix_known = 1;
      return;
    end
    nr = (r == VT - 1) ? 0 : r + 1;
    trig = (c == 0) && (nr < H);
    old_front = m_front;
    sel = (c == 0) ? !m_front : m_front;
    if (r < H && c < W) begin
      exp_pix_known = slot_ok[sel];
      exp_pix = slot_ok[sel] ? img(slot_line[sel], c) : 24'h0;
    end else begin
      exp_pix_known = 1;
      exp_pix = 24'h0;
    end
    if (c == 0) m_front = !m_front;
    if (m_f != 0) begin
      if (trig) m_over = 1;
      if (m_f == W + 1) begin
        slot_ok[m_fill] = 1;
        slot_line[m_fill] = m_line;
        m_f = 0;
      end else begin
        m_f++;
      end
    end else if (trig) begin
      m_f = 1;
      m_fill = old_front;
      slot_ok[m_fill] = 0;
      m_line = nr;
      m_start = 16'((BASE + nr * W) % 65536);
    end
    exp_busy = (m_f != 0);
    exp_rd = (m_f >= 1) && (m_f <= W);
    if (exp_rd) m_addr = m_start + 16'(m_f - 1);
  endtask

  task automatic step(input bit rst_n, input int r, input int c);
    reset = rst_n; row = 10'(r); column = 10'(c);
    model_edge(rst_n, r, c);
    @(posedge clk);
    @(negedge clk);
    chk("mem_rd_en", {31'h0, mem_rd_en}, {31'h0, exp_rd});
    chk("busy", {31'h0, busy}, {31'h0, exp_busy});
    chk("overrun", {31'h0, overrun}, {31'h0, m_over});
    chk("mem_addr", {16'h0, mem_addr}, {16'h0, m_addr});
    if (exp_pix_known) chk("pixel", {8'h0, blue, green, red}, {8'h0, exp_pix});
    if (mem_rd_en === 1'b1) begin
      if (seq_rd == 0) seq_first = mem_addr;
      else if (mem_addr !== seq_prev + 16'd1) seq_bad++;
      seq_prev = mem_addr;
      seq_rd++;
    end
    if (busy === 1'b1) seq_busy++;
  endtask

  task automatic scan(input int r, input int len);
    for (int c = 0; c < len; c++) step(1'b1, r, c);
  endtask

  task automatic begin_seq();
    seq_rd = 0; seq_busy = 0; seq_bad = 0; seq_first = '0; seq_prev = '0;
  endtask

  task automatic fetch_checks(input string name, input int start);
    chk({name, "_rd_cycles"}, seq_rd, 200);
    chk({name, "_first_addr"}, {16'h0, seq_first}, start);
    chk({name, "_last_addr"}, {16'h0, seq_prev}, start + 199);
    chk({name, "_addr_gaps"}, seq_bad, 0);
    chk({name, "_busy_cycles"}, seq_busy, 201);
    $display("seq %s: rd=%0d first=%0d last=%0d busy=%0d", name, seq_rd, seq_first, seq_prev, seq_busy);
  endtask

  task automatic set_vec(input int i, input string name, input int r, input int c, input logic [23:0] rgb);
    vecs[i].name = name; vecs[i].r = r; vecs[i].c = c; vecs[i].rgb = rgb;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int r, len;
    for (int i = 0; i < 65536; i++) mem_img[i] = $urandom;
    mem_img[5] = 32'h00332211;
    slot_ok[0] = 0; slot_ok[1] = 0;
    slot_line[0] = 0; slot_line[1] = 0;
    begin_seq();

    set_vec(0, "px_r0_c5",     0,    5, 24'h332211);
    set_vec(1, "black_col250", 0,  250, 24'h0);
    set_vec(2, "black_row300", 300,  5, 24'h0);
    set_vec(3, "px_last_col",  0,  199, img(0, 199));
    set_vec(4, "black_col200", 0,  200, 24'h0);
    set_vec(5, "px_row199",    199,  7, img(0, 7));
    set_vec(6, "black_row200", 200,  7, 24'h0);
    set_vec(7, "px_col1",      0,    1, img(0, 1));

    // Reset held for 3 cycles, then no fetch without a trigger.
    for (int i = 0; i < 3; i++) step(1'b0, 100, 50);
    chk("reset_rgb", {8'h0, red, green, blue}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_overrun", {31'h0, overrun}, 32'h0);
    chk("reset_rd_en", {31'h0, mem_rd_en}, 32'h0);
    begin_seq();
    for (int c = 51; c < 61; c++) step(1'b1, 100, c);
    chk("post_reset_no_rd", seq_rd, 0);
    $display("seq reset: done");

    begin_seq(); scan(524, 260); fetch_checks("frame_start", 0);
    begin_seq(); scan(0, 260);   fetch_checks("line1", 200);

    foreach (vecs[i]) begin
      step(1'b1, vecs[i].r, vecs[i].c);
      chk(vecs[i].name, {8'h0, blue, green, red}, {8'h0, vecs[i].rgb});
      $display("vec %s: row=%0d col=%0d rgb=%06h", vecs[i].name, vecs[i].r, vecs[i].c, {blue, green, red});
    end

    for (int i = 1; i < 4; i++) scan(i, 260);
    scan(198, 260);
    begin_seq(); scan(199, 260);
    chk("row199_no_rd", seq_rd, 0);
    chk("row199_no_busy", seq_busy, 0);
    $display("seq row199: rd=%0d busy=%0d", seq_rd, seq_busy);

    for (int i = 0; i < 10; i++) begin
      r = $urandom_range(0, VT - 1);
      len = $urandom_range(205, 300);
      scan(r, len);
      $display("rand line row=%0d len=%0d", r, len);
    end

    // Second trigger 50 cycles into a fetch.
    begin_seq();
    for (int c = 0; c < 50; c++) step(1'b1, 10, c);
    for (int c = 0; c < 260; c++) step(1'b1, 11, c);
    fetch_checks("overrun", 2200);
    chk("overrun_set", {31'h0, overrun}, 32'h1);
    for (int c = 260; c < 280; c++) step(1'b1, 11, c);
    chk("overrun_sticky", {31'h0, overrun}, 32'h1);

    // Reset at the 100th address of a fetch.
    begin_seq();
    found = 0;
    for (int c = 0; c < 260 && !found; c++) begin
      step(1'b1, 20, c);
      if (mem_rd_en === 1'b1 && mem_addr === 16'd4299) found = 1;
    end
    chk("midfetch_found", {31'h0, found}, 32'h1);
    chk("midfetch_count", seq_rd, 100);
    step(1'b0, 20, 150);
    chk("midfetch_rd_en", {31'h0, mem_rd_en}, 32'h0);
    chk("midfetch_busy", {31'h0, busy}, 32'h0);
    chk("midfetch_overrun", {31'h0, overrun}, 32'h0);
    for (int c = 151; c < 170; c++) step(1'b1, 20, c);
    begin_seq(); scan(30, 260); fetch_checks("restart", 6200);
    scan(31, 260);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
